// File: rtl/dmem_responder.sv
// dmem_responder: one-request-at-a-time data-memory responder with byte-lane
// alignment over an internal byte-writable word array.
// Ports: clk, rst (sync, active-high); request req_valid/req_ready, addr,
// wdata, write_enable, read_enable, write_wstrb (size code, bytes = code+1);
// response resp_valid/resp_ready, rdata (right-aligned), resp_err.
// Macro MISALIGNED_SPLIT_EN: when defined, misaligned accesses are legal and
// word-crossing ones are split into two beats; otherwise misaligned = error.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [1:0]  write_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

  state_e state_q, state_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] idx_q;
  logic [1:0]    a_q;
  logic [1:0]    sz_q;
  logic [31:0]   wdata_q;
  logic          we_q, re_q, err_q, cross_q;
  logic [31:0]   rd0_q, rd1_q;

  logic          acc;
  logic [2:0]    n_in, end_in;
  logic          cross_in, range_err, mis_err, err_in;
  logic [30:0]   hi_idx;

  logic [3:0]    nmask;
  logic [7:0]    msk;
  logic [63:0]   wsh, rwin;
  logic [3:0]    be;
  logic [31:0]   wlane, bmask;
  logic [AW-1:0] widx;
  logic          go_b1;

  assign acc = req_valid && req_ready;

  // request checks, all taken at accept time
  always_comb begin
    n_in      = {1'b0, write_wstrb} + 3'd1;
    end_in    = {1'b0, addr[1:0]} + n_in;
    cross_in  = end_in > 3'd4;
    hi_idx    = {1'b0, addr[31:2]} + 31'(cross_in);
    range_err = hi_idx >= 31'(DEPTH_WORDS);
    mis_err   = !SPLIT &&
                ((write_wstrb == 2'd1 && addr[0]) ||
                 (write_wstrb == 2'd3 && addr[1:0] != 2'd0));
    err_in    = (write_enable || read_enable) &&
                (write_wstrb == 2'd2 ||
                 (write_enable && read_enable) ||
                 range_err || mis_err);
  end

  // lane masks over a two-word window: low word = BEAT0, high word = BEAT1
  always_comb begin
    nmask = {sz_q == 2'd3, sz_q >= 2'd2, sz_q >= 2'd1, 1'b1};
    msk   = 8'(nmask) << a_q;
    wsh   = 64'(wdata_q) << {a_q, 3'b000};
    rwin  = {rd1_q, rd0_q} >> {a_q, 3'b000};
    bmask = {{8{nmask[3]}}, {8{nmask[2]}},
             {8{nmask[1]}}, {8{nmask[0]}}};
    be    = (state_q == BEAT1) ? msk[7:4] : msk[3:0];
    wlane = (state_q == BEAT1) ? wsh[63:32] : wsh[31:0];
    widx  = (state_q == BEAT1) ? idx_q + AW'(1) : idx_q;
    go_b1 = SPLIT && cross_q && !err_q && (we_q || re_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (req_valid) state_d = BEAT0;
      BEAT0: state_d = go_b1 ? BEAT1 : RESP;
      BEAT1: state_d = RESP;
      RESP:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE) && !rst;
    resp_valid = (state_q == RESP) && !rst;
    resp_err   = resp_valid && err_q;
    rdata      = (resp_valid && re_q && !err_q) ?
                 (rwin[31:0] & bmask) : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      a_q     <= '0;
      sz_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      err_q   <= 1'b0;
      cross_q <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      if (acc) begin
        idx_q   <= addr[AW+1:2];
        a_q     <= addr[1:0];
        sz_q    <= write_wstrb;
        wdata_q <= wdata;
        we_q    <= write_enable;
        re_q    <= read_enable;
        err_q   <= err_in;
        cross_q <= cross_in;
      end
      if (state_q == BEAT0) rd0_q <= mem[widx];
      if (state_q == BEAT1) rd1_q <= mem[widx];
    end
  end

  // a reset in BEAT1 suppresses the second-word write
  always_ff @(posedge clk) begin
    if (!rst && we_q && !err_q &&
        (state_q == BEAT0 || state_q == BEAT1)) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[widx][8*l +: 8] <= wlane[8*l +: 8];
      end
    end
  end

endmodule
